// File: rtl/univ_register_if.sv
// Control, data and status signals of univ_register; the tri-state bus driver
// output stays a plain module port so the bus can be resolved with other drivers.
interface univ_register_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             enable;
  logic [2:0]       op;
  logic [WIDTH-1:0] data;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             zero;

  modport master (
    output load, enable, op, data, serial_in,
    input  q, carry, zero
  );

  modport slave (
    input  load, enable, op, data, serial_in,
    output q, carry, zero
  );
endinterface

// File: rtl/univ_register.sv
// Universal register: load/inc/dec/shift/rotate/sync-clear with carry, zero and tri-state bus.
// Optional macro UNIV_REG_SAT_EN makes INC/DEC saturate instead of wrapping.
module univ_register #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                clr,
  univ_register_if.slave      ctl,
  output logic [WIDTH-1:0]    bus
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_INC  = 3'b001,
    OP_DEC  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_SCLR = 3'b111
  } op_e;

  op_e              op_sel;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             c_r;
  logic             c_nxt;

  assign op_sel = op_e'(ctl.op);

  always_comb begin
    q_nxt = q_r;
    c_nxt = c_r;
    case (op_sel)
      OP_LOAD: q_nxt = ctl.data;
      OP_INC: begin
        c_nxt = &q_r;
`ifdef UNIV_REG_SAT_EN
        q_nxt = (&q_r) ? q_r : q_r + ONE;
`else
        q_nxt = q_r + ONE;
`endif
      end
      OP_DEC: begin
        c_nxt = ~|q_r;
`ifdef UNIV_REG_SAT_EN
        q_nxt = (~|q_r) ? q_r : q_r - ONE;
`else
        q_nxt = q_r - ONE;
`endif
      end
      OP_SHL: begin
        q_nxt = {q_r[WIDTH-2:0], ctl.serial_in};
        c_nxt = q_r[WIDTH-1];
      end
      OP_SHR: begin
        q_nxt = {ctl.serial_in, q_r[WIDTH-1:1]};
        c_nxt = q_r[0];
      end
      OP_ROL: begin
        q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        c_nxt = q_r[WIDTH-1];
      end
      OP_ROR: begin
        q_nxt = {q_r[0], q_r[WIDTH-1:1]};
        c_nxt = q_r[0];
      end
      OP_SCLR: begin
        q_nxt = '0;
        c_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // load is an active-low strobe; with it high the register simply holds.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_r <= RST_Q;
      c_r <= 1'b0;
    end else if (!ctl.load) begin
      q_r <= q_nxt;
      c_r <= c_nxt;
    end
  end

  assign ctl.q     = q_r;
  assign ctl.carry = c_r;
  assign ctl.zero  = ~|q_r;
  assign bus       = ctl.enable ? 'z : q_r;

endmodule
